// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared constants, default vector table and request priority encoder for pc_sequencer.
package pc_seq_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int MAX_VEC = 32;
  localparam int VEC_DEF_LEN = 11;
  localparam int VEC_DEF [VEC_DEF_LEN] = '{150, 148, 8, 144, 48, 48, 76, 98, 138, 130, 184};
  function automatic int vec_default(input int i);
    return (i < VEC_DEF_LEN) ? VEC_DEF[i] : 0;
  endfunction
  function automatic int lowest_set(input logic [MAX_VEC-1:0] req);
    int idx;
    idx = 0;
    for (int i = MAX_VEC - 1; i >= 0; i--) if (req[i]) idx = i;
    return idx;
  endfunction
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch-control bundle between the fetch controller (master) and pc_sequencer (slave).
interface pc_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int NUM_VEC = 11
) ();
    logic                       stall;
    logic [ADDR_W-1:0]          next;
    logic [NUM_VEC-1:0]         vec_req;
    logic                       call;
    logic                       ret;
    logic                       vec_we;
    logic [$clog2(NUM_VEC)-1:0] vec_widx;
    logic [ADDR_W-1:0]          vec_wdata;
    logic [ADDR_W-1:0]          actual;
    logic                       ras_empty;
    logic                       ras_full;
    logic                       ras_ovf;
    logic                       ras_unf;
    modport master (
        output stall, next, vec_req, call, ret, vec_we, vec_widx, vec_wdata,
        input  actual, ras_empty, ras_full, ras_ovf, ras_unf
    );
    modport slave (
        input  stall, next, vec_req, call, ret, vec_we, vec_widx, vec_wdata,
        output actual, ras_empty, ras_full, ras_ovf, ras_unf
    );
endinterface

// File: rtl/pc_sequencer_ras.sv
// pc_ras: circular return-address stack; a push while full overwrites the oldest entry.
module pc_ras #(
    parameter int ADDR_W = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full,
    output logic              ovf,
    output logic              unf
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);
    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PW-1:0] wp, wp_inc, wp_dec;
    logic [CW-1:0] cnt;
    // wp is the next write slot; explicit wrap keeps non-power-of-two depths correct
    assign wp_inc = (wp == PW'(RAS_DEPTH - 1)) ? '0 : wp + PW'(1);
    assign wp_dec = (wp == '0) ? PW'(RAS_DEPTH - 1) : wp - PW'(1);
    assign top = mem[wp_dec];
    assign empty = (cnt == '0);
    assign full = (cnt == CW'(RAS_DEPTH));
    always_ff @(negedge clk) begin
        if (!rst) begin
            wp <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            ovf <= push && full;
            unf <= pop && empty;
            if (push) begin
                mem[wp] <= din;
                wp <= wp_inc;
                if (!full) cnt <= cnt + CW'(1);
            end else if (pop && !empty) begin
                wp <= wp_dec;
                cnt <= cnt - CW'(1);
            end
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC register with programmable vector table, stall hold and return stack.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_VEC = 11,
    parameter int RAS_DEPTH = 4,
    parameter int RESET_PC = 0
) (
    input logic clk,
    input logic rst,
    pc_sequencer_if.slave bus
);
    localparam int VW = $clog2(NUM_VEC);
    logic [ADDR_W-1:0] tbl [NUM_VEC];
    logic [ADDR_W-1:0] ras_top;
    logic [VW-1:0] sel;
    logic any_req, push, pop;
    assign any_req = |bus.vec_req;
    assign sel = VW'(lowest_set(MAX_VEC'(bus.vec_req)));
    assign push = !bus.stall && !bus.ret && any_req && bus.call;
    assign pop = !bus.stall && bus.ret;
    pc_ras #(.ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bus.next),
        .top   (ras_top),
        .empty (bus.ras_empty),
        .full  (bus.ras_full),
        .ovf   (bus.ras_ovf),
        .unf   (bus.ras_unf)
    );
    // a jump reads the pre-edge table entry, so a same-edge write is seen only next time
    always_ff @(negedge clk) begin
        if (!rst) begin
            bus.actual <= ADDR_W'(RESET_PC);
            for (int i = 0; i < NUM_VEC; i++) tbl[i] <= ADDR_W'(vec_default(i));
        end else begin
            if (bus.vec_we && 32'(bus.vec_widx) < NUM_VEC) tbl[bus.vec_widx] <= bus.vec_wdata;
            if (!bus.stall)
                bus.actual <= bus.ret ? (bus.ras_empty ? bus.next : ras_top) :
                              any_req ? tbl[sel] : bus.next;
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks of pc_sequencer against a queue-based reference model.
module tb_pc_sequencer;
    localparam int AW = 8, NV = 11, RD = 4;
    localparam int DEF [NV] = '{150, 148, 8, 144, 48, 48, 76, 98, 138, 130, 184};
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    pc_sequencer_if #(.ADDR_W(AW), .NUM_VEC(NV)) bus ();
    pc_sequencer #(.ADDR_W(AW), .NUM_VEC(NV), .RAS_DEPTH(RD), .RESET_PC(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );
    int n_cmp = 0, n_bad = 0;
    int m_pc, m_ovf, m_unf;
    int m_tbl [NV];
    int m_stk [$];
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    // reference: stack is a queue whose back is the top; a full push drops the front
    task automatic model_edge();
        int low, tgt;
        if (!rst) begin
            m_pc = 0; m_ovf = 0; m_unf = 0;
            m_stk.delete();
            foreach (m_tbl[i]) m_tbl[i] = DEF[i];
            return;
        end
        m_ovf = 0; m_unf = 0;
        low = -1;
        for (int i = NV - 1; i >= 0; i--) if (bus.vec_req[i]) low = i;
        tgt = (low >= 0) ? m_tbl[low] : 0;
        if (!bus.stall) begin
            if (bus.ret) begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else begin m_pc = int'(bus.next); m_unf = 1; end
            end else if (low >= 0) begin
                m_pc = tgt;
                if (bus.call) begin
                    if (m_stk.size() == RD) begin void'(m_stk.pop_front()); m_ovf = 1; end
                    m_stk.push_back(int'(bus.next));
                end
            end else m_pc = int'(bus.next);
        end
        if (bus.vec_we && int'(bus.vec_widx) < NV) m_tbl[bus.vec_widx] = int'(bus.vec_wdata);
    endtask
    task automatic step();
        @(negedge clk);
        model_edge();
        @(posedge clk);
        chk("actual", 32'(bus.actual), m_pc);
        chk("ras_empty", 32'(bus.ras_empty), 32'(m_stk.size() == 0));
        chk("ras_full", 32'(bus.ras_full), 32'(m_stk.size() == RD));
        chk("ras_ovf", 32'(bus.ras_ovf), m_ovf);
        chk("ras_unf", 32'(bus.ras_unf), m_unf);
    endtask
    task automatic idle();
        bus.stall = 0; bus.ret = 0; bus.call = 0; bus.vec_req = '0;
        bus.vec_we = 0; bus.vec_widx = '0; bus.vec_wdata = '0;
    endtask
    initial begin
        idle();
        bus.next = 8'd0;
        rst = 0;
        step(); step();
        chk("dir_reset_pc", 32'(bus.actual), 0);
        chk("dir_reset_empty", 32'(bus.ras_empty), 1);
        rst = 1; bus.next = 8'd1;
        step();
        chk("dir_release", 32'(bus.actual), 1);
        bus.vec_req = 11'b00001000100; bus.next = 8'd2;
        step();
        chk("dir_prio", 32'(bus.actual), 8);
        bus.vec_req = 11'b00000001000; bus.call = 1; bus.next = 8'd50;
        step();
        bus.call = 0; bus.vec_req = 11'b00001000100; bus.ret = 1;
        step();
        chk("dir_ret_over_vec", 32'(bus.actual), 50);
        idle(); bus.next = 8'd20;
        step();
        bus.stall = 1; bus.vec_req = 11'b1;
        repeat (3) begin step(); chk("dir_stall_hold", 32'(bus.actual), 20); end
        bus.stall = 0;
        step();
        chk("dir_stall_release", 32'(bus.actual), 150);
        idle(); bus.next = 8'd11; bus.call = 1; bus.vec_req = 11'b00000001000;
        step();
        chk("dir_call", 32'(bus.actual), 144);
        idle(); bus.ret = 1;
        step();
        chk("dir_ret", 32'(bus.actual), 11);
        chk("dir_ret_empty", 32'(bus.ras_empty), 1);
        idle(); bus.call = 1; bus.vec_req = 11'b1;
        for (int k = 1; k <= 5; k++) begin bus.next = 8'(k); step(); end
        chk("dir_ovf", 32'(bus.ras_ovf), 1);
        idle(); bus.ret = 1; bus.next = 8'd77;
        for (int k = 5; k >= 2; k--) begin step(); chk("dir_pop", 32'(bus.actual), k); end
        step();
        chk("dir_unf", 32'(bus.ras_unf), 1);
        chk("dir_unf_pc", 32'(bus.actual), 77);
        idle(); bus.vec_we = 1; bus.vec_widx = 4'd4; bus.vec_wdata = 8'd200; bus.vec_req = 11'b00000010000;
        step();
        chk("dir_wr_old", 32'(bus.actual), 48);
        bus.vec_we = 0;
        step();
        chk("dir_wr_new", 32'(bus.actual), 200);
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 49) != 0);
            bus.stall = ($urandom_range(0, 5) == 0);
            bus.ret = ($urandom_range(0, 3) == 0);
            bus.call = $urandom_range(0, 1) == 1;
            bus.vec_req = $urandom_range(0, 1) ? NV'($urandom) & NV'($urandom) & NV'($urandom) : '0;
            bus.next = 8'($urandom);
            bus.vec_we = ($urandom_range(0, 2) == 0);
            bus.vec_widx = 4'($urandom_range(0, 15));
            bus.vec_wdata = 8'($urandom);
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the processor fetch stage. It supersedes the fixed-target PC register with a runtime-programmable vector table of NUM_VEC jump targets, a stall hold, and a hardware return-address stack for call/return. It sits between the PC+1 adder and instruction memory: `next` comes from the adder, `actual` addresses instruction ROM.

## Interface

- ADDR_W, 8: PC / address width.
- NUM_VEC, 11: number of vector-table entries and jump request lines.
- RAS_DEPTH, 4: return-address stack entries, ≥ 2.
- RESET_PC, 0: value loaded into `actual` on reset.

Ports:

- clk  in  1  single clock; all state updates on the falling edge.
- rst  in  1  synchronous, active-low reset, sampled on the falling edge of clk.
- stall  in  1  hold PC and stack this cycle.
- next  in  ADDR_W  sequential PC from adder.
- vec_req  in  NUM_VEC  jump requests; lowest set index wins.
- call  in  1  qualifies a vector jump as a call that pushes `next`.
- ret  in  1  pop return stack into PC.
- vec_we  in  1  vector-table write enable.
- vec_widx  in  $clog2(NUM_VEC)  table write index.
- vec_wdata  in  ADDR_W  table write data.
- actual  out  ADDR_W  current PC.
- ras_empty  out  1  stack holds 0 entries.
- ras_full  out  1  stack holds RAS_DEPTH entries.
- ras_ovf  out  1  one-cycle pulse: push while full.
- ras_unf  out  1  one-cycle pulse: pop while empty.

## Operation

- PC update priority per edge: reset > stall > ret > vector jump > `next`.
- Reset (rst=0): `actual`=RESET_PC; stack count=0; vector table reloaded from package default (entries ≥ default length load 0); ras_ovf=ras_unf=0; ras_empty=1, ras_full=0.
- Stall: `actual`, stack and pulses held/cleared (pulses 0); ignores ret/vec_req/call. Table writes still take effect.
- Ret: if stack non-empty, `actual`←top, count−1. If empty, `actual`←`next`, ras_unf=1. Ret outranks any vec_req in the same cycle.
- Vector jump (any vec_req bit set, no ret): `actual`←table[lowest set index]. If call=1, push `next`; when full, oldest entry discarded (circular), count stays RAS_DEPTH, ras_ovf=1.
- call with no vec_req: ignored, no push.
- Otherwise `actual`←`next`.
- Table write: table[vec_widx]←vec_wdata at the edge; a jump to that index in the same cycle uses the old value. vec_widx ≥ NUM_VEC is ignored.
- No arithmetic in block; all addresses pass through unmodified at ADDR_W. Stack pointer wraps modulo RAS_DEPTH.

## Timing

- Request to `actual` latency: 1 falling edge. Outputs are registered.
- Flags ras_empty and ras_full reflect the count after the edge.
- ras_ovf and ras_unf are high for exactly the cycle following the offending edge.
- Reset mid-call/ret: reset wins. The stack is emptied and the pending push/pop is discarded.

## Structure

- Package `pc_seq_pkg` holds:
  - ADDR_W default.
  - Default vector-table constant: 150, 148, 8, 144, 48, 48, 76, 98, 138, 130, 184.
  - Priority-encoder function for vec_req.
- Sub-module `pc_ras`: the circular return stack (push, pop, top, count, full, empty, ovf, unf), parametrised by ADDR_W and RAS_DEPTH.

## Test plan

- Reset: rst=0 for 2 edges with RESET_PC=0 → actual=0, ras_empty=1, ras_full=0, flags 0. Release with next=1 → actual=1.
- Priority: vec_req=bits 2 and 6 set → actual=8 (default entry 2). Ret asserted with a non-empty stack in the same cycle → actual=popped value instead.
- Stall: actual=20, stall=1 with vec_req[0]=1 for 3 edges → actual stays 20. Stall released → actual=150.
- Call/ret: next=11, call and vec_req[3] → actual=144, stack top=11. Then ret → actual=11, ras_empty=1.
- Overflow/underflow, RAS_DEPTH=4:
  - Five calls pushing 1..5 → ras_ovf pulse on the 5th.
  - Four rets return 5, 4, 3, 2.
  - A 5th ret → ras_unf=1 and actual=next.
- Table write: vec_we with idx=4, data=200 while vec_req[4]=1 → actual=48 this edge. vec_req[4] on the next edge → actual=200.
